// File: rtl/async_req_arbiter.sv
// Two-requester round-robin arbiter for a shared resource with four-phase
// handshakes, a BUSY-state watchdog and a sticky timeout error flag.
module async_req_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic async_req0,
  input  logic async_req1,
  input  logic done,
  input  logic clr_err,
  output logic start,
  output logic grant_id,
  output logic ack0,
  output logic ack1,
  output logic busy,
  output logic timeout_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2,
    ACK   = 2'd3
  } state_t;

  logic [1:0]       meta_q;
  logic [1:0]       sreq_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_grant_q, last_grant_d;
  logic             grant_id_q, grant_id_d;
  logic             start_q, start_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             winner;

  // Requests cross into clk through two flops each; only sreq_q is trusted.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      meta_q <= 2'b00;
      sreq_q <= 2'b00;
    end else begin
      meta_q <= {async_req1, async_req0};
      sreq_q <= meta_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    err_d        = err_q;
    winner       = 1'b0;
    if (clr_err) err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (|sreq_q) begin
          // With both pending the requester not served last time wins.
          winner       = (sreq_q[0] && sreq_q[1]) ? ~last_grant_q : sreq_q[1];
          grant_id_d   = winner;
          last_grant_d = winner;
          state_d      = GRANT;
        end
      end
      GRANT: begin
        cnt_d   = '0;
        state_d = BUSY;
      end
      BUSY: begin
        if (done) begin
          state_d = ACK;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ACK: begin
        if (!sreq_q[grant_id_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered copies of the next-state decode.
    start_d = (state_d == GRANT);
    busy_d  = (state_d != IDLE);
    ack0_d  = (state_d == ACK) && !grant_id_d;
    ack1_d  = (state_d == ACK) &&  grant_id_d;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      start_q      <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      start_q      <= start_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign start       = start_q;
  assign grant_id    = grant_id_q;
  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign busy        = busy_q;
  assign timeout_err = err_q;

endmodule
